// File: rtl/alu_cmd_sequencer_if.sv
// Command/response handshake bundle between an upstream client and alu_cmd_sequencer.
// master = client that issues commands and consumes responses; slave = the sequencer.
interface alu_cmd_sequencer_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_opcode;
    logic [7:0]  cmd_a;
    logic [7:0]  cmd_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_result;
    logic [1:0]  rsp_opcode;
    logic        rsp_error;

    modport master (
        output cmd_valid, cmd_opcode, cmd_a, cmd_b, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_result, rsp_opcode, rsp_error
    );

    modport slave (
        input  cmd_valid, cmd_opcode, cmd_a, cmd_b, rsp_ready,
        output cmd_ready, rsp_valid, rsp_result, rsp_opcode, rsp_error
    );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// Single-command front-end for alu_top: latch operands, clear the ALU, pulse begin_op,
// wait for done (with timeout) and hand the result back over a valid/ready response.
module alu_cmd_sequencer #(
    parameter int CLR_CYCLES     = 1,
    parameter int BEGIN_CYCLES   = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    alu_cmd_sequencer_if.slave   bus,
    output logic                 alu_reset,
    output logic                 alu_begin_op,
    output logic [1:0]           alu_opcode,
    output logic [7:0]           alu_a,
    output logic [7:0]           alu_b,
    input  logic [15:0]          alu_result,
    input  logic                 alu_done,
    output logic                 busy
);
    localparam int CNT_MAX0 = (CLR_CYCLES > BEGIN_CYCLES) ? CLR_CYCLES : BEGIN_CYCLES;
    localparam int CNT_MAX  = (CNT_MAX0 > TIMEOUT_CYCLES) ? CNT_MAX0 : TIMEOUT_CYCLES;
    localparam int CW       = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CW-1:0] CLR_LAST   = CW'(CLR_CYCLES - 1);
    localparam logic [CW-1:0] BEGIN_LAST = CW'(BEGIN_CYCLES - 1);
    localparam logic [CW-1:0] TMO_LAST   = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        ISSUE = 3'd2,
        WAIT  = 3'd3,
        RESP  = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    opcode_q, opcode_d;
    logic [7:0]    a_q, a_d;
    logic [7:0]    b_q, b_d;
    logic [15:0]   rsp_result_q, rsp_result_d;
    logic [1:0]    rsp_opcode_q, rsp_opcode_d;
    logic          rsp_error_q, rsp_error_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic          begin_op_q, begin_op_d;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            opcode_q     <= '0;
            a_q          <= '0;
            b_q          <= '0;
            rsp_result_q <= '0;
            rsp_opcode_q <= '0;
            rsp_error_q  <= 1'b0;
            rsp_valid_q  <= 1'b0;
            begin_op_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            opcode_q     <= opcode_d;
            a_q          <= a_d;
            b_q          <= b_d;
            rsp_result_q <= rsp_result_d;
            rsp_opcode_q <= rsp_opcode_d;
            rsp_error_q  <= rsp_error_d;
            rsp_valid_q  <= rsp_valid_d;
            begin_op_q   <= begin_op_d;
        end
    end

    // Next-state and datapath capture
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        opcode_d     = opcode_q;
        a_d          = a_q;
        b_d          = b_q;
        rsp_result_d = rsp_result_q;
        rsp_opcode_d = rsp_opcode_q;
        rsp_error_d  = rsp_error_q;
        unique case (state_q)
            IDLE: begin
                if (bus.cmd_valid) begin
                    opcode_d = bus.cmd_opcode;
                    a_d      = bus.cmd_a;
                    b_d      = bus.cmd_b;
                    cnt_d    = '0;
                    state_d  = CLEAR;
                end
            end
            CLEAR: begin
                if (cnt_q == CLR_LAST) begin
                    cnt_d   = '0;
                    state_d = ISSUE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ISSUE: begin
                if (cnt_q == BEGIN_LAST) begin
                    cnt_d   = '0;
                    state_d = WAIT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WAIT: begin
                if (alu_done) begin
                    rsp_result_d = alu_result;
                    rsp_opcode_d = opcode_q;
                    rsp_error_d  = 1'b0;
                    state_d      = RESP;
                end else if (cnt_q == TMO_LAST) begin
                    rsp_result_d = '0;
                    rsp_opcode_d = opcode_q;
                    rsp_error_d  = 1'b1;
                    state_d      = RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                if (bus.rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs: begin_op and rsp_valid are registered off the next state so they
    // line up exactly with ISSUE and RESP.
    always_comb begin
        alu_reset     = reset | (state_q == CLEAR);
        bus.cmd_ready = (state_q == IDLE);
        busy          = (state_q != IDLE);
        begin_op_d    = (state_d == ISSUE);
        rsp_valid_d   = (state_d == RESP);
    end

    assign alu_begin_op   = begin_op_q;
    assign alu_opcode     = opcode_q;
    assign alu_a          = a_q;
    assign alu_b          = b_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_result = rsp_result_q;
    assign bus.rsp_opcode = rsp_opcode_q;
    assign bus.rsp_error  = rsp_error_q;
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer driving a small behavioural ALU stub
// (add/sub done combinationally, mul/div done after a fixed iteration count).
module tb_alu_cmd_sequencer;
    logic        clk = 1'b0;
    logic        reset;
    logic        alu_reset, alu_begin_op, alu_done, busy;
    logic [1:0]  alu_opcode;
    logic [7:0]  alu_a, alu_b;
    logic [15:0] alu_result;
    logic        stuck;
    logic [3:0]  mcnt;
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_mis = 0;

    alu_cmd_sequencer_if bus ();

    alu_cmd_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus.slave),
        .alu_reset    (alu_reset),
        .alu_begin_op (alu_begin_op),
        .alu_opcode   (alu_opcode),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_result   (alu_result),
        .alu_done     (alu_done),
        .busy         (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ALU stub: mul/div finish 8 cycles after the first begin_op cycle
    always @(posedge clk) begin
        if (alu_reset) mcnt <= 4'd0;
        else if (alu_begin_op || (mcnt != 4'd0 && mcnt != 4'd8)) mcnt <= mcnt + 4'd1;
    end

    always_comb begin
        alu_done   = !stuck && (!alu_opcode[1] || mcnt == 4'd8);
        alu_result = 16'h0000;
        case (alu_opcode)
            2'b00: alu_result = {8'h00, alu_a} + {8'h00, alu_b};
            2'b01: alu_result = {8'h00, alu_a} - {8'h00, alu_b};
            2'b10: alu_result = {8'h00, alu_a} * {8'h00, alu_b};
            default: alu_result = (alu_b == 8'h00) ? 16'hFFFF : {8'h00, alu_a / alu_b};
        endcase
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one command, wait for its response, optionally consume it.
    task automatic run_cmd(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                           input bit consume, output int lat, output logic [15:0] res,
                           output logic err, output logic [1:0] rop, output int rdy_hi,
                           output int rst_hi, output int beg_hi);
        int k;
        int acc;
        k = 0; rdy_hi = 0; rst_hi = 0; beg_hi = 0;
        bus.cmd_opcode = op; bus.cmd_a = a; bus.cmd_b = b; bus.cmd_valid = 1'b1;
        while (!bus.cmd_ready && k < 100) begin
            @(negedge clk);
            k++;
        end
        check_val("accept_wait", 32'(k < 100), 32'd1);
        acc = cyc + 1;
        @(posedge clk);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        k = 0;
        while (!bus.rsp_valid && k < 300) begin
            if (bus.cmd_ready) rdy_hi++;
            if (alu_reset) rst_hi++;
            if (alu_begin_op) beg_hi++;
            @(negedge clk);
            k++;
        end
        check_val("rsp_wait", 32'(bus.rsp_valid), 32'd1);
        lat = cyc - acc;
        res = bus.rsp_result;
        err = bus.rsp_error;
        rop = bus.rsp_opcode;
        if (consume) begin
            bus.rsp_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            bus.rsp_ready = 1'b0;
        end
        $display("cmd op=%0d a=%0d b=%0d -> result=%0d err=%0d lat=%0d", op, a, b, res, err, lat);
    endtask

    initial begin
        int lat, rdy_hi, rst_hi, beg_hi;
        logic [15:0] res;
        logic err;
        logic [1:0] rop;
        int seen;

        reset = 1'b1; stuck = 1'b0;
        bus.cmd_valid = 1'b0; bus.cmd_opcode = 2'b00; bus.cmd_a = 8'h00; bus.cmd_b = 8'h00;
        bus.rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check_val("rst_begin_op", 32'(alu_begin_op), 32'd0);
        check_val("rst_alu_reset", 32'(alu_reset), 32'd1);
        check_val("rst_alu_a", 32'(alu_a), 32'd0);
        check_val("rst_rsp_result", 32'(bus.rsp_result), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check_val("idle_alu_reset", 32'(alu_reset), 32'd0);

        // Test 1: add
        run_cmd(2'b00, 8'd5, 8'd3, 1'b1, lat, res, err, rop, rdy_hi, rst_hi, beg_hi);
        check_val("add_latency", 32'(lat), 32'd4);
        check_val("add_result", 32'(res), 32'd8);
        check_val("add_error", 32'(err), 32'd0);

        // Test 2: sub, pulse widths
        run_cmd(2'b01, 8'd10, 8'd4, 1'b1, lat, res, err, rop, rdy_hi, rst_hi, beg_hi);
        check_val("sub_result", 32'(res), 32'd6);
        check_val("sub_opcode", 32'(rop), 32'd1);
        check_val("sub_alu_reset_clks", 32'(rst_hi), 32'd1);
        check_val("sub_begin_op_clks", 32'(beg_hi), 32'd2);

        // Test 3: mul then div, no ready while in flight
        run_cmd(2'b10, 8'd7, 8'd3, 1'b1, lat, res, err, rop, rdy_hi, rst_hi, beg_hi);
        check_val("mul_result", 32'(res), 32'd21);
        check_val("mul_latency", 32'(lat), 32'd10);
        check_val("mul_ready_inflight", 32'(rdy_hi), 32'd0);
        check_val("mul_busy_resp", 32'(busy), 32'd0);
        run_cmd(2'b11, 8'd20, 8'd3, 1'b1, lat, res, err, rop, rdy_hi, rst_hi, beg_hi);
        check_val("div_result", 32'(res), 32'd6);
        check_val("div_opcode", 32'(rop), 32'd3);
        check_val("div_ready_inflight", 32'(rdy_hi), 32'd0);

        // Test 4: response back-pressure with a pending command
        run_cmd(2'b00, 8'd100, 8'd50, 1'b0, lat, res, err, rop, rdy_hi, rst_hi, beg_hi);
        check_val("bp_result", 32'(res), 32'd150);
        bus.cmd_opcode = 2'b01; bus.cmd_a = 8'd9; bus.cmd_b = 8'd2; bus.cmd_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_val("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
            check_val("bp_rsp_result", 32'(bus.rsp_result), 32'd150);
            check_val("bp_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        check_val("bp_idle_ready", 32'(bus.cmd_ready), 32'd1);
        check_val("bp_idle_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        run_cmd(2'b01, 8'd9, 8'd2, 1'b1, lat, res, err, rop, rdy_hi, rst_hi, beg_hi);
        check_val("bp_next_result", 32'(res), 32'd7);
        check_val("bp_next_latency", 32'(lat), 32'd4);

        // Test 5: timeout, 64 WAIT cycles after 1 CLEAR + 2 ISSUE
        stuck = 1'b1;
        run_cmd(2'b10, 8'd7, 8'd7, 1'b1, lat, res, err, rop, rdy_hi, rst_hi, beg_hi);
        check_val("tmo_latency", 32'(lat), 32'd67);
        check_val("tmo_error", 32'(err), 32'd1);
        check_val("tmo_result", 32'(res), 32'd0);
        stuck = 1'b0;

        // Test 6: reset in WAIT of a div
        bus.cmd_opcode = 2'b11; bus.cmd_a = 8'd200; bus.cmd_b = 8'd7; bus.cmd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        repeat (5) @(negedge clk);
        check_val("mid_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        check_val("mid_alu_reset", 32'(alu_reset), 32'd1);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check_val("mid_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        check_val("mid_busy_after", 32'(busy), 32'd0);
        seen = 0;
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.rsp_valid) seen++;
        end
        bus.rsp_ready = 1'b0;
        check_val("mid_no_rsp", 32'(seen), 32'd0);
        run_cmd(2'b00, 8'd1, 8'd1, 1'b1, lat, res, err, rop, rdy_hi, rst_hi, beg_hi);
        check_val("post_rst_result", 32'(res), 32'd2);
        check_val("post_rst_error", 32'(err), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
